// File: rtl/padd_pkg.sv
// Shared constants and the result record for the prefix-adder collect stage.
// Optional field: res_zero flag under PADD_COLLECT_ZERO_FLAG_EN.
package padd_pkg;

    localparam int PADD_WIDTH = 32;
    localparam int PADD_LAT   = 5;
    localparam int PADD_TAG_W = 4;
    localparam int PADD_DEPTH = 8;

    typedef struct packed {
        logic [PADD_WIDTH-1:0] sum;
        logic                  cout;
        logic [PADD_TAG_W-1:0] tag;
`ifdef PADD_COLLECT_ZERO_FLAG_EN
        logic                  zero;
`endif
    } padd_result_t;

    // Builds one FIFO entry from the adder output captured at the end of the pipe.
    function automatic padd_result_t padd_pack(
        input logic [PADD_WIDTH-1:0] sum,
        input logic                  cout,
        input logic [PADD_TAG_W-1:0] tag
    );
        padd_result_t r;
        r.sum  = sum;
        r.cout = cout;
        r.tag  = tag;
`ifdef PADD_COLLECT_ZERO_FLAG_EN
        r.zero = (sum == '0);
`endif
        return r;
    endfunction

endpackage

// File: rtl/padd_result_collect_if.sv
// Issue, adder-return and result handshake bundle of padd_result_collect.
// res_zero exists only when PADD_COLLECT_ZERO_FLAG_EN is defined.
interface padd_result_collect_if #(
    parameter int WIDTH = padd_pkg::PADD_WIDTH,
    parameter int TAG_W = padd_pkg::PADD_TAG_W,
    parameter int DEPTH = padd_pkg::PADD_DEPTH
);

    // Both ports use valid/ready: a transfer happens on a clock edge where valid
    // and ready are both high; valid never depends combinationally on ready.
    logic                     issue_valid;
    logic [TAG_W-1:0]         issue_tag;
    logic                     issue_ready;
    logic [WIDTH-1:0]         sum_in;
    logic                     cout_in;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_sum;
    logic                     res_cout;
    logic [TAG_W-1:0]         res_tag;
    logic [$clog2(DEPTH):0]   res_count;

`ifdef PADD_COLLECT_ZERO_FLAG_EN
    logic                     res_zero;

    modport slave (
        input  issue_valid, issue_tag, sum_in, cout_in, res_ready,
        output issue_ready, res_valid, res_sum, res_cout, res_tag, res_count, res_zero
    );

    modport master (
        output issue_valid, issue_tag, sum_in, cout_in, res_ready,
        input  issue_ready, res_valid, res_sum, res_cout, res_tag, res_count, res_zero
    );
`else
    modport slave (
        input  issue_valid, issue_tag, sum_in, cout_in, res_ready,
        output issue_ready, res_valid, res_sum, res_cout, res_tag, res_count
    );

    modport master (
        output issue_valid, issue_tag, sum_in, cout_in, res_ready,
        input  issue_ready, res_valid, res_sum, res_cout, res_tag, res_count
    );
`endif

endinterface

// File: rtl/padd_fifo.sv
// Synchronous result FIFO of padd_result_t entries with occupancy count.
// Entry layout follows padd_pkg (zero flag under PADD_COLLECT_ZERO_FLAG_EN).
module padd_fifo
    import padd_pkg::*;
#(
    parameter int DEPTH = PADD_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  padd_result_t           i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output padd_result_t           o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    padd_result_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same edge frees the slot, so a full FIFO may still accept.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/padd_result_collect.sv
// Collect stage behind the fixed-latency prefix adder: valid/tag shadow pipe,
// credit-based issue_ready and a result FIFO. Option: PADD_COLLECT_ZERO_FLAG_EN.
module padd_result_collect
    import padd_pkg::*;
#(
    parameter int WIDTH = PADD_WIDTH,
    parameter int LAT   = PADD_LAT,
    parameter int DEPTH = PADD_DEPTH,
    parameter int TAG_W = PADD_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    padd_result_collect_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] USED_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] USED_ONE = CW'(1);

    logic [LAT-1:0]            r_vld_sr;
    logic [LAT-1:0][TAG_W-1:0] r_tag_sr;
    logic [CW-1:0]             r_used;

    logic                      w_issue_ready;
    logic                      w_acc;
    logic                      w_pop;
    logic                      w_fifo_valid;
    logic [WIDTH-1:0]          w_sum_in;
    padd_result_t              w_capture;
    padd_result_t              w_head;
    logic [CW-1:0]             w_count;

    // Ready depends only on the registered credit count, never on res_ready.
    assign w_issue_ready = (r_used < USED_MAX);
    assign w_acc         = bus.issue_valid & w_issue_ready;
    assign w_pop         = w_fifo_valid & bus.res_ready;

    // The adder cannot stall, so the shadow pipe shifts every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
            r_tag_sr <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[LAT-2:0], w_acc};
            r_tag_sr <= {r_tag_sr[LAT-2:0], bus.issue_tag};
        end
    end

    // Credits cover both in-flight adds and buffered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_used <= r_used + USED_ONE;
                2'b01:   r_used <= r_used - USED_ONE;
                default: r_used <= r_used;
            endcase
        end
    end

    assign w_sum_in  = bus.sum_in;
    assign w_capture = padd_pack(w_sum_in, bus.cout_in, r_tag_sr[LAT-1]);

    padd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld_sr[LAT-1]),
        .i_data  (w_capture),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.issue_ready = w_issue_ready;
    assign bus.res_valid   = w_fifo_valid;
    assign bus.res_sum     = w_head.sum;
    assign bus.res_cout    = w_head.cout;
    assign bus.res_tag     = w_head.tag;
    assign bus.res_count   = w_count;
`ifdef PADD_COLLECT_ZERO_FLAG_EN
    assign bus.res_zero    = w_head.zero;
`endif

endmodule

// File: tb/tb_padd_result_collect.sv
// Directed bench for padd_result_collect with a behavioural 5-stage adder and
// an expected-result queue; res_zero is checked when PADD_COLLECT_ZERO_FLAG_EN is set.
module tb_padd_result_collect;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int EW    = 37;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    padd_result_collect_if #(.WIDTH(32), .TAG_W(4), .DEPTH(DEPTH)) bus ();

    padd_result_collect dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_pops = 0;
    int m_used = 0;
    logic [EW-1:0] exp_q[$];

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [32:0] add_pipe [LAT];

    // Adder model: no reset, output valid LAT edges after operands.
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.sum_in  = add_pipe[LAT-1][31:0];
    assign bus.cout_in = add_pipe[LAT-1][32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepted adds, compare every popped head in order.
    always @(posedge clk) begin
        logic [32:0]   s;
        logic [EW-1:0] e;
        logic          acc;
        logic          pop;
        if (rst) begin
            m_used <= 0;
            exp_q.delete();
        end else begin
            acc = bus.issue_valid && bus.issue_ready;
            pop = bus.res_valid && bus.res_ready;
            if (pop) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", {bus.res_sum, bus.res_cout, bus.res_tag}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", {bus.res_sum, bus.res_cout, bus.res_tag}, e);
                end
            end
            if (acc) begin
                s = {1'b0, op_a} + {1'b0, op_b};
                exp_q.push_back({s[31:0], s[32], bus.issue_tag});
            end
            m_used <= m_used + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    task automatic drive(input logic v, input logic [3:0] t, input logic rr);
        bus.issue_valid = v;
        bus.issue_tag   = t;
        bus.res_ready   = rr;
        op_a            = $urandom;
        op_b            = $urandom;
    endtask

    function automatic int fill_count(input int j);
        if (j <= 5) return 0;
        if (j - 5 > DEPTH) return DEPTH;
        return j - 5;
    endfunction

    initial begin
        int pops0;
        int accepts;
        drive(1'b0, 4'd0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        chk("rst_res_cout", bus.res_cout, 0);
        chk("rst_res_tag", bus.res_tag, 0);
        chk("rst_res_count", bus.res_count, 0);
        rst = 1'b0;

        // Single add 1 + FFFFFFFF, tag 3: result visible at T+6
        @(negedge clk);
        drive(1'b1, 4'd3, 1'b1);
        op_a = 32'h0000_0001;
        op_b = 32'hFFFF_FFFF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus.issue_valid = 1'b0;
        end
        chk("single_valid_t5", bus.res_valid, 0);
        @(negedge clk);
        chk("single_valid_t6", bus.res_valid, 1);
        chk("single_sum", bus.res_sum, 0);
        chk("single_cout", bus.res_cout, 1);
        chk("single_tag", bus.res_tag, 3);
        chk("single_count", bus.res_count, 1);
`ifdef PADD_COLLECT_ZERO_FLAG_EN
        chk("single_zero", bus.res_zero, 1);
`endif
        @(negedge clk);
        chk("single_drained", bus.res_valid, 0);

        // Streaming 20 adds with the consumer always ready
        pops0 = n_pops;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b1, 4'(i), 1'b1);
            chk("stream_ready", bus.issue_ready, 1);
            chk("stream_valid", bus.res_valid, (i >= 6) ? 1 : 0);
        end
        @(negedge clk);
        bus.issue_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("stream_pops", n_pops - pops0, 20);
        chk("stream_q_empty", exp_q.size(), 0);

        // Consumer stalled: exactly DEPTH accepts, count reaches 8 at T+13
        accepts = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            drive(1'b1, 4'(j), 1'b0);
            chk("fill_ready", bus.issue_ready, (j < DEPTH) ? 1 : 0);
            chk("fill_count", bus.res_count, fill_count(j));
            if (bus.issue_ready) accepts++;
        end
        chk("fill_accepts", accepts, DEPTH);

        // One pop from full re-opens a credit the next cycle
        @(negedge clk);
        chk("full_ready", bus.issue_ready, 0);
        chk("full_count", bus.res_count, DEPTH);
        drive(1'b1, 4'd7, 1'b1);
        @(negedge clk);
        chk("pop_reopen_ready", bus.issue_ready, 1);
        chk("pop_reopen_count", bus.res_count, 7);
        drive(1'b1, 4'd9, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("refull_ready", bus.issue_ready, 0);
            chk("refull_count", bus.res_count, 7);
            drive((k < 5) ? 1'b1 : 1'b0, 4'(k), (k == 5) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("push_pop_count", bus.res_count, 7);
        chk("push_pop_ready", bus.issue_ready, 1);
        drive(1'b0, 4'd0, 1'b1);
        repeat (10) @(negedge clk);
        chk("drain_count", bus.res_count, 0);
        chk("drain_q_empty", exp_q.size(), 0);

        // Reset with 2 buffered and 3 in flight
        @(negedge clk); drive(1'b1, 4'd1, 1'b0);
        @(negedge clk); drive(1'b1, 4'd2, 1'b0);
        @(negedge clk); drive(1'b0, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_rst_count", bus.res_count, 2);
        drive(1'b1, 4'd4, 1'b0);
        @(negedge clk); drive(1'b1, 4'd5, 1'b0);
        @(negedge clk); drive(1'b1, 4'd6, 1'b0);
        @(negedge clk); drive(1'b0, 4'd0, 1'b0);
        chk("pre_rst_valid", bus.res_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_ready", bus.issue_ready, 1);
        chk("mid_rst_count", bus.res_count, 0);
        chk("mid_rst_sum", bus.res_sum, 0);
        chk("mid_rst_tag", bus.res_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bus.res_valid, 0);
        end

        // Random issue/consume traffic checked against the credit model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("credit", bus.issue_ready, (m_used < DEPTH) ? 1 : 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b1);
        repeat (20) @(negedge clk);
        chk("rand_q_empty", exp_q.size(), 0);
        chk("rand_count", bus.res_count, 0);
        chk("rand_ready", bus.issue_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
